// File: rtl/mpt_pkg.sv
// Shared MPT walker types and constants: bus width, walk depth, flush status
// and the memory arbiter's index type and FSM states.
package mpt_pkg;

  localparam int XLEN                   = 64;
  localparam int SMMPT52_WALKING_LEVELS = 4;
  localparam int MPTW_MAX_OUTST         = 4;

  typedef enum logic [1:0] {
    MPT_FLUSHED_NONE      = 2'd0,
    MPT_FLUSHED_ONGOING   = 2'd1,
    MPT_FLUSHED_COMPLETED = 2'd2
  } mptw_flush_status_e;

  typedef logic [$clog2(SMMPT52_WALKING_LEVELS)-1:0] mptw_arb_idx_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } mptw_arb_state_e;

endpackage

// File: rtl/mptw_mem_arbiter_outst_fifo.sv
// In-order FIFO of requester indices for memory requests awaiting a response.
// A push while full and a pop while empty are both ignored.
module mptw_outst_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mptw_mem_arbiter.sv
// Shares the MPT-entry memory read port between walker level requesters and routes
// in-order responses back. Define MPTW_ARB_FIXED_PRIO_EN for highest-index-wins priority.
//
// state | meaning
// ARB   | normal issue and response routing
// DRAIN | flush: no issue, outstanding responses consumed silently
// DONE  | flush complete, reported for one cycle
module mptw_mem_arbiter
  import mpt_pkg::*;
#(
  parameter int NUM_REQ   = SMMPT52_WALKING_LEVELS,
  parameter int MAX_OUTST = MPTW_MAX_OUTST
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [NUM_REQ*XLEN-1:0] req_addr_i,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic [XLEN-1:0]         mem_req_addr_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [XLEN-1:0]         mem_rsp_data_i,
  input  logic                    mem_rsp_err_i,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [XLEN-1:0]         rsp_data_o,
  output logic                    rsp_err_o,
  input  logic                    flush_i,
  output logic [1:0]              flush_status_o,
  output logic                    busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_OUTST) + 1;

  mptw_arb_state_e    state_q;
  mptw_flush_status_e flush_status_q;
  logic               lock_q;
  logic [IW-1:0]      lock_idx_q;
  logic [IW-1:0]      arb_idx;
  logic [IW-1:0]      win_idx;
  logic               issue_en;
  logic               mem_hs;
  logic               rsp_pop;
  logic               rsp_fwd;
  logic [IW-1:0]      fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full;
  logic               fifo_empty;

`ifdef MPTW_ARB_FIXED_PRIO_EN
  always_comb begin : fixed_pick
    logic [IW-1:0] cand;
    arb_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'(i);
      if (req_valid_i[cand]) arb_idx = cand;
    end
  end
`else
  logic [IW-1:0] rr_ptr_q;

  // Walk downwards so the smallest offset from the pointer is assigned last and wins.
  always_comb begin : rr_pick
    logic [IW-1:0] cand;
    arb_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid_i[cand]) arb_idx = cand;
    end
  end
`endif

  assign win_idx         = lock_q ? lock_idx_q : arb_idx;
  assign issue_en        = (state_q == ARB) && !fifo_full && !rst_i;
  assign mem_req_valid_o = issue_en && (|req_valid_i);
  assign mem_req_addr_o  = mem_req_valid_o ? req_addr_i[win_idx*XLEN +: XLEN] : '0;
  assign mem_hs          = mem_req_valid_o && mem_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    if (mem_req_valid_o) req_ready_o[win_idx] = mem_req_ready_i;
  end

  assign rsp_pop = mem_rsp_valid_i && !fifo_empty && !rst_i;
  assign rsp_fwd = rsp_pop && (state_q == ARB);

  always_comb begin
    rsp_valid_o = '0;
    if (rsp_fwd) rsp_valid_o[fifo_head] = 1'b1;
  end

  assign rsp_data_o     = rsp_fwd ? mem_rsp_data_i : '0;
  assign rsp_err_o      = rsp_fwd && mem_rsp_err_i;
  assign busy_o         = !fifo_empty;
  assign flush_status_o = flush_status_q;

  mptw_outst_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (IW)
  ) u_outst_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (mem_hs),
    .data_i  (win_idx),
    .pop_i   (rsp_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ARB;
      flush_status_q <= MPT_FLUSHED_NONE;
      lock_q         <= 1'b0;
      lock_idx_q     <= '0;
`ifndef MPTW_ARB_FIXED_PRIO_EN
      rr_ptr_q       <= '0;
`endif
    end else begin
      // Hold the winner while memory stalls so the address cannot change under it.
      if (mem_hs) begin
        lock_q <= 1'b0;
      end else if (mem_req_valid_o && !lock_q) begin
        lock_q     <= 1'b1;
        lock_idx_q <= arb_idx;
      end else if (state_q != ARB) begin
        lock_q <= 1'b0;
      end
`ifndef MPTW_ARB_FIXED_PRIO_EN
      if (mem_hs) rr_ptr_q <= (win_idx == IW'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
`endif
      case (state_q)
        ARB: begin
          if (flush_i) begin
            state_q        <= DRAIN;
            flush_status_q <= MPT_FLUSHED_ONGOING;
          end
        end
        DRAIN: begin
          if ((fifo_count == '0) || ((fifo_count == CW'(1)) && rsp_pop)) begin
            state_q        <= DONE;
            flush_status_q <= MPT_FLUSHED_COMPLETED;
          end
        end
        DONE: begin
          state_q        <= ARB;
          flush_status_q <= MPT_FLUSHED_NONE;
`ifndef MPTW_ARB_FIXED_PRIO_EN
          rr_ptr_q       <= '0;
`endif
        end
        default: begin
          state_q        <= ARB;
          flush_status_q <= MPT_FLUSHED_NONE;
        end
      endcase
    end
  end

  rsp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(mem_rsp_valid_i && fifo_empty));

endmodule

// File: tb/tb_mptw_mem_arbiter.sv
// Scoreboard bench for mptw_mem_arbiter: expected grants/responses are queued by the
// stimulus process and checked by a negedge monitor; state checks are done inline.
module tb_mptw_mem_arbiter;
  import mpt_pkg::*;

  localparam int N = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    req_valid_i;
  logic [N-1:0]    req_ready_o;
  logic [N*XLEN-1:0] req_addr_i;
  logic            mem_req_valid_o;
  logic            mem_req_ready_i;
  logic [XLEN-1:0] mem_req_addr_o;
  logic            mem_rsp_valid_i;
  logic [XLEN-1:0] mem_rsp_data_i;
  logic            mem_rsp_err_i;
  logic [N-1:0]    rsp_valid_o;
  logic [XLEN-1:0] rsp_data_o;
  logic            rsp_err_o;
  logic            flush_i;
  logic [1:0]      flush_status_o;
  logic            busy_o;

  mptw_mem_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_addr_i      (req_addr_i),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_err_i   (mem_rsp_err_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_data_o      (rsp_data_o),
    .rsp_err_o       (rsp_err_o),
    .flush_i         (flush_i),
    .flush_status_o  (flush_status_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [N-1:0] onehot; logic [XLEN-1:0] addr; } grant_t;
  typedef struct { logic [N-1:0] onehot; logic [XLEN-1:0] data; logic err; } rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  grant_t g;
  rsp_t   r;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] addr_of(input int i);
    return XLEN'(64'h1000 * (i + 1));
  endfunction

  task automatic exp_grant(input int i);
    grant_t e;
    e.onehot = N'(1) << i;
    e.addr   = addr_of(i);
    gq.push_back(e);
  endtask

  task automatic exp_rsp(input int i, input logic [XLEN-1:0] d, input logic e);
    rsp_t x;
    x.onehot = N'(1) << i;
    x.data   = d;
    x.err    = e;
    rq.push_back(x);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    req_valid_i     = '0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    mem_rsp_err_i   = 1'b0;
    flush_i         = 1'b0;
  endtask

  task automatic drive_rsp(input logic [XLEN-1:0] d, input logic e);
    mem_rsp_valid_i = 1'b1;
    mem_rsp_data_i  = d;
    mem_rsp_err_i   = e;
  endtask

  // Monitor: every handshake and every forwarded response must match the queue head.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (mem_req_valid_o && mem_req_ready_i) begin
        if (gq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_grant: got ready 0x%0h addr 0x%0h expected no grant", req_ready_o, mem_req_addr_o);
        end else begin
          g = gq.pop_front();
          check("grant_ready", XLEN'(req_ready_o), XLEN'(g.onehot));
          check("grant_addr", mem_req_addr_o, g.addr);
        end
      end
      if (rsp_valid_o != '0) begin
        if (rq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_rsp: got rsp_valid 0x%0h expected none", rsp_valid_o);
        end else begin
          r = rq.pop_front();
          check("rsp_onehot", XLEN'(rsp_valid_o), XLEN'(r.onehot));
          check("rsp_data", rsp_data_o, r.data);
          check("rsp_err", XLEN'(rsp_err_o), XLEN'(r.err));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) req_addr_i[i*XLEN +: XLEN] = addr_of(i);
    idle();
    rst_i = 1'b1;
    repeat (2) step();
    rst_i = 1'b0;
    #1;
    check("rst_mem_valid", XLEN'(mem_req_valid_o), 0);
    check("rst_req_ready", XLEN'(req_ready_o), 0);
    check("rst_rsp_valid", XLEN'(rsp_valid_o), 0);
    check("rst_busy", XLEN'(busy_o), 0);
    check("rst_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_NONE));

    // Round robin between requesters 0 and 2.
    req_valid_i = 4'b0101; mem_req_ready_i = 1'b1;
    exp_grant(0); exp_grant(2); exp_grant(0); exp_grant(2);
    repeat (4) step();
    idle();
    #1;
    check("rr_busy_full", XLEN'(busy_o), 1);
    for (int k = 0; k < 4; k++) begin
      exp_rsp((k % 2 == 0) ? 0 : 2, XLEN'(64'hA0 + k), 1'b0);
      drive_rsp(XLEN'(64'hA0 + k), 1'b0);
      step();
    end
    idle();
    #1;
    check("rr_busy_empty", XLEN'(busy_o), 0);

    // Lock: requester 1 stalls, requester 0 arrives with higher RR priority.
    req_valid_i = 4'b0010; mem_req_ready_i = 1'b0;
    #1;
    check("lock_valid", XLEN'(mem_req_valid_o), 1);
    check("lock_addr0", mem_req_addr_o, 64'h2000);
    step();
    req_valid_i = 4'b0011;
    #1;
    check("lock_addr1", mem_req_addr_o, 64'h2000);
    step();
    #1;
    check("lock_addr2", mem_req_addr_o, 64'h2000);
    step();
    mem_req_ready_i = 1'b1;
    exp_grant(1);
    #1;
    check("lock_ready", XLEN'(req_ready_o), 64'h2);
    step();
    idle();
    exp_rsp(1, 64'h55, 1'b0);
    drive_rsp(64'h55, 1'b0);
    step();
    idle();

    // Fill the FIFO, stall on the 5th attempt, pop one, then issue again.
    req_valid_i = 4'b1111; mem_req_ready_i = 1'b1;
    exp_grant(2); exp_grant(3); exp_grant(0); exp_grant(1);
    repeat (4) step();
    drive_rsp(64'hDEAD, 1'b0);
    exp_rsp(2, 64'hDEAD, 1'b0);
    #1;
    check("full_no_valid", XLEN'(mem_req_valid_o), 0);
    check("full_no_ready", XLEN'(req_ready_o), 0);
    step();
    mem_rsp_valid_i = 1'b0;
    exp_grant(2);
    #1;
    check("refill_valid", XLEN'(mem_req_valid_o), 1);
    step();
    idle();

    // Error response for requester 3.
    exp_rsp(3, 64'hBEEF, 1'b1);
    drive_rsp(64'hBEEF, 1'b1);
    #1;
    check("err_onehot", XLEN'(rsp_valid_o), 64'h8);
    check("err_flag", XLEN'(rsp_err_o), 1);
    step();
    idle();

    // Flush with three outstanding.
    flush_i = 1'b1;
    #1;
    check("flush_arb_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_NONE));
    step();
    flush_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_rsp(64'h77, 1'b0);
      #1;
      check("drain_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_ONGOING));
      check("drain_rsp_quiet", XLEN'(rsp_valid_o), 0);
      step();
    end
    idle();
    req_valid_i = 4'b0110; mem_req_ready_i = 1'b1;
    #1;
    check("done_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_COMPLETED));
    check("done_no_issue", XLEN'(mem_req_valid_o), 0);
    check("done_busy", XLEN'(busy_o), 0);
    step();
    exp_grant(1);
    #1;
    check("resume_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_NONE));
    step();
    idle();

    // Reset with two outstanding and the lock held on requester 0.
    req_valid_i = 4'b0100; mem_req_ready_i = 1'b1;
    exp_grant(2);
    step();
    req_valid_i = 4'b0001; mem_req_ready_i = 1'b0;
    #1;
    check("prelock_addr", mem_req_addr_o, 64'h1000);
    step();
    idle();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid", XLEN'(mem_req_valid_o), 0);
    check("mid_rst_ready", XLEN'(req_ready_o), 0);
    check("mid_rst_rsp", XLEN'(rsp_valid_o), 0);
    check("mid_rst_busy", XLEN'(busy_o), 0);
    check("mid_rst_status", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_NONE));
    req_valid_i = 4'b0010;
    #1;
    check("mid_rst_unlocked", mem_req_addr_o, 64'h2000);
    step();
    mem_req_ready_i = 1'b1;
    exp_grant(1);
    step();
    idle();
    exp_rsp(1, 64'h99, 1'b0);
    drive_rsp(64'h99, 1'b0);
    step();
    idle();

    // Flush with nothing outstanding: COMPLETED two cycles after flush_i.
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    #1;
    check("eflush_ongoing", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_ONGOING));
    step();
    #1;
    check("eflush_completed", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_COMPLETED));
    step();
    #1;
    check("eflush_none", XLEN'(flush_status_o), XLEN'(MPT_FLUSHED_NONE));

    step();
    check("grants_left", XLEN'(gq.size()), 0);
    check("rsps_left", XLEN'(rq.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mptw_mem_arbiter.md
Name: mptw_mem_arbiter

Overview:
- Shares the single MPT-entry memory read port between the MPT walker's per-level lookup requesters.
- Round-robin grants a requester, issues its MPTE pointer to memory and records the requester index in an in-order outstanding FIFO.
- Routes each in-order memory response back to the requester recorded for it.
- Sequences walker flush: stops issuing new requests, drains outstanding responses, reports status with mptw_flush_status_e.

Parameters:
- NUM_REQ, 4 (SMMPT52_WALKING_LEVELS): number of requesters; legal range 2..8.
- MAX_OUTST, 4: outstanding FIFO depth; power of two, at least 2.
- XLEN, from mpt_pkg: address and data width.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_addr_i  in  NUM_REQ*XLEN  per-requester MPTE pointer (spa_t_u raw)
- mem_req_valid_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts the request
- mem_req_addr_o  out  XLEN  memory request address
- mem_rsp_valid_i  in  1  in-order memory response valid (always accepted)
- mem_rsp_data_i  in  XLEN  response data (mpt_entry_t)
- mem_rsp_err_i  in  1  bus error flag for the response
- rsp_valid_o  out  NUM_REQ  one-hot response strobe
- rsp_data_o  out  XLEN  response data, broadcast to all requesters
- rsp_err_o  out  1  response error flag, broadcast
- flush_i  in  1  flush request, level; sampled while in ARB
- flush_status_o  out  2  mptw_flush_status_e
- busy_o  out  1  high when the outstanding FIFO is non-empty

Behaviour:
- Reset values: all outputs 0; flush_status_o = MPT_FLUSHED_NONE; RR pointer = 0; FIFO empty; state ARB.
- Issue condition: in state ARB with count < MAX_OUTST.
  - mem_req_valid_o = OR of req_valid_i.
  - Winner is the first valid index at or after the RR pointer, wrapping NUM_REQ-1 -> 0.
  - mem_req_addr_o = winner's address, combinational.
  - req_ready_o[winner] = mem_req_ready_i.
- Issue is not allowed when count == MAX_OUTST or the state is not ARB: mem_req_valid_o = 0, req_ready_o = 0.
- Lock: once mem_req_valid_o is asserted and not yet accepted, the winner index is registered and held until the handshake. A newly valid, higher-priority requester must not change the winner, address or index.
- On handshake (mem_req_valid_o & mem_req_ready_i):
  - push the winner index into the FIFO;
  - RR pointer = winner+1 mod NUM_REQ;
  - release the lock.
- Response:
  - On mem_rsp_valid_i with the FIFO non-empty, pop the head.
  - In ARB, the same cycle: rsp_valid_o[head] = 1, rsp_data_o = mem_rsp_data_i, rsp_err_o = mem_rsp_err_i (zero added latency).
  - While draining, pop but keep rsp_valid_o = 0.
  - mem_rsp_valid_i with the FIFO empty is ignored; the simulation assertion fires.
- Same-cycle push and pop: both take effect, count unchanged.
  - The full check uses the registered count, so no push happens at count == MAX_OUTST even if a pop occurs in the same cycle.
- FSM:
  - ARB: normal operation. If flush_i = 1 -> DRAIN. A handshake in that same cycle still completes and its response is drained.
  - DRAIN: flush_status_o = MPT_FLUSHED_ONGOING; no issue. When count == 0, or count == 1 with a pop this cycle -> DONE.
  - DONE: flush_status_o = MPT_FLUSHED_COMPLETED for exactly one cycle -> ARB, with the RR pointer reset to 0.
- A flush with the FIFO empty takes ARB -> DRAIN -> DONE, so COMPLETED appears 2 cycles after flush_i.
- flush_i still high on return to ARB starts a new flush.
- Reset mid-operation: all state is cleared and in-flight responses are lost. The memory side must be reset in the same cycle.

Optional Feature:
- Macro MPTW_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, highest index wins (deepest walk level first); the RR pointer is removed. Lock behaviour is unchanged.
- Undefined: round-robin as described above.

Decomposition:
- Add to mpt_pkg:
  - typedef mptw_arb_idx_t = logic [$clog2(NUM_REQ)-1:0];
  - localparam MPTW_MAX_OUTST = 4;
  - mptw_arb_state_e {ARB, DRAIN, DONE}.
- Reuse the existing mptw_flush_status_e.
- One sub-module, mptw_outst_fifo: synchronous FIFO of requester indices with push, pop, count, full and empty.

Test Plan:
- Requesters 0 and 2 valid, mem_req_ready_i = 1 every cycle -> grants alternate 0, 2, 0, 2; addresses 0x1000 / 0x3000 presented in the matching cycles.
- Requester 1 valid at 0x2000 with mem_req_ready_i = 0 for 3 cycles; requester 0 becomes valid at cycle 1 -> address stays 0x2000 and the index stays 1 until the handshake on cycle 3.
- 4 grants with no responses -> mem_req_valid_o = 0 on the 5th attempt; one response pops, and the next cycle issues again. The response goes to the first-granted requester with data 0xDEAD.
- flush_i with 3 outstanding -> ONGOING; the 3 responses are dropped with rsp_valid_o = 0; COMPLETED for 1 cycle, then NONE and issue resumes.
- mem_rsp_err_i = 1 on the response for requester 3 -> rsp_valid_o = 4'b1000 and rsp_err_o = 1 in the same cycle.
- rst_i asserted with 2 outstanding and the lock active -> next cycle: all outputs 0, busy_o = 0, status NONE.
